ofmap_buffer: RTL

- Parametrised output-feature-map buffer: accepts LANES-wide partial-sum vectors from the PE array and drains them one word per cycle to the DMA/writeback path.
- Adds a valid/ready handshake, per-lane write mask, an accumulate mode, a length-programmed streaming read engine and a sticky wrap-error flag.
- Storage is a flop array of 2^ADDR_BIT words. Reads and writes are mutually exclusive per buffer; the controller ping-pongs two instances.

---
 rtl/ofmap_buffer_if.sv | 35 +++
 rtl/ofmap_buffer.sv | 109 ++++++++++
 2 files changed

// File: rtl/ofmap_buffer_if.sv
// Handshake/bus bundle for ofmap_buffer: PE-array write beats and the DMA read stream.
// The master modport belongs to the PE array/controller side, the slave modport to the buffer itself.
interface ofmap_buffer_if #(
   parameter int ADDR_BIT = 7,
   parameter int DATA_W   = 32,
   parameter int LANES    = 8
);
   logic                      wr_valid;
   logic                      wr_ready;
   logic [ADDR_BIT-1:0]       wr_addr;
   logic [LANES*DATA_W-1:0]   wr_data;
   logic [LANES-1:0]          wr_mask;
   logic                      wr_acc;
   logic                      rd_start;
   logic [ADDR_BIT-1:0]       rd_base;
   logic [ADDR_BIT:0]         rd_len;
   logic                      rd_busy;
   logic                      rd_valid;
   logic                      rd_ready;
   logic [DATA_W-1:0]         rd_data;
   logic                      rd_last;
   logic                      err_wrap;

   modport master (
      output wr_valid, wr_addr, wr_data, wr_mask, wr_acc,
      output rd_start, rd_base, rd_len, rd_ready,
      input  wr_ready, rd_busy, rd_valid, rd_data, rd_last, err_wrap
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_mask, wr_acc,
      input  rd_start, rd_base, rd_len, rd_ready,
      output wr_ready, rd_busy, rd_valid, rd_data, rd_last, err_wrap
   );
endinterface

// File: rtl/ofmap_buffer.sv
// Output-feature-map buffer: masked/accumulating LANES-wide writes, length-programmed read stream.
// Optional macro OFMAP_RELU_EN clips negative words to zero as they are loaded into rd_data.
module ofmap_buffer #(
   parameter int ADDR_BIT = 7,
   parameter int DATA_W   = 32,
   parameter int LANES    = 8
) (
   input  logic           CLK,
   input  logic           RSTN,
   ofmap_buffer_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_BIT;
   localparam logic [ADDR_BIT:0] DEPTH_LEN = (ADDR_BIT+1)'(DEPTH);

   typedef enum logic {IDLE, READ} state_t;

   state_t                r_state;
   logic [DATA_W-1:0]     r_ram [DEPTH];
   logic [DATA_W-1:0]     r_rdData;
   logic                  r_rdValid;
   logic [ADDR_BIT-1:0]   r_ptr;
   logic [ADDR_BIT-1:0]   r_remaining;
   logic                  r_errWrap;

   logic                  w_wrFire;
   logic                  w_wrWraps;
   logic [ADDR_BIT-1:0]   w_laneAddr [LANES];
   logic [ADDR_BIT:0]     w_clampedLen;

   function automatic logic [DATA_W-1:0] loadWord(input logic [DATA_W-1:0] word);
`ifdef OFMAP_RELU_EN
      return word[DATA_W-1] ? '0 : word;
`else
      return word;
`endif
   endfunction

   assign bus.wr_ready = (r_state == IDLE);
   assign bus.rd_busy  = (r_state == READ);
   assign bus.rd_valid = r_rdValid;
   assign bus.rd_data  = r_rdData;
   assign bus.rd_last  = r_rdValid && (r_remaining == '0);
   assign bus.err_wrap = r_errWrap;

   assign w_wrFire     = bus.wr_valid && bus.wr_ready;
   assign w_clampedLen = (bus.rd_len > DEPTH_LEN) ? DEPTH_LEN : bus.rd_len;

   // Lane addresses wrap modulo depth; the carry out of the extended sum flags the wrap.
   always_comb begin
      w_wrWraps = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         logic [ADDR_BIT:0] w_fullAddr;
         w_fullAddr    = {1'b0, bus.wr_addr} + (ADDR_BIT+1)'(i);
         w_laneAddr[i] = w_fullAddr[ADDR_BIT-1:0];
         if (bus.wr_mask[i] && w_fullAddr[ADDR_BIT])
            w_wrWraps = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_wrFire) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.wr_mask[i])
               r_ram[w_laneAddr[i]] <= bus.wr_acc
                  ? r_ram[w_laneAddr[i]] + bus.wr_data[i*DATA_W +: DATA_W]
                  : bus.wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Reads sample r_ram before this edge's write lands, giving read-before-write on a shared edge.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state     <= IDLE;
         r_rdData    <= '0;
         r_rdValid   <= 1'b0;
         r_ptr       <= '0;
         r_remaining <= '0;
         r_errWrap   <= 1'b0;
      end else begin
         if (w_wrFire && w_wrWraps)
            r_errWrap <= 1'b1;
         case (r_state)
            IDLE: begin
               if (bus.rd_start && (bus.rd_len != '0)) begin
                  r_rdData    <= loadWord(r_ram[bus.rd_base]);
                  r_rdValid   <= 1'b1;
                  r_ptr       <= bus.rd_base + 1'b1;
                  r_remaining <= ADDR_BIT'(w_clampedLen - 1'b1);
                  r_state     <= READ;
               end
            end
            READ: begin
               if (r_rdValid && bus.rd_ready) begin
                  if (r_remaining == '0) begin
                     r_rdValid <= 1'b0;
                     r_state   <= IDLE;
                  end else begin
                     r_rdData    <= loadWord(r_ram[r_ptr]);
                     r_ptr       <= r_ptr + 1'b1;
                     r_remaining <= r_remaining - 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
